// File: rtl/td4_prog_loader_if.sv
// Serial load link and CPU fetch port of the TD4 program loader.
// master = host/CPU side, slave = loader.
interface td4_prog_loader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              start;
   logic              ser_valid;
   logic              sdi;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] wr_addr;
   logic              err;

   modport master (
      output start, ser_valid, sdi, cpu_addr,
      input  cpu_data, cpu_rst_n, busy, done, wr_addr, err
   );

   modport slave (
      input  start, ser_valid, sdi, cpu_addr,
      output cpu_data, cpu_rst_n, busy, done, wr_addr, err
   );
endinterface

// File: rtl/td4_prog_loader.sv
// TD4 program memory: bit-serial MSB-first loader plus CPU fetch port.
// Define TD4_LOADER_CHECKSUM_EN to add a trailing checksum byte (CHK).
module td4_prog_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input logic              clk,
   input logic              rst,
   td4_prog_loader_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef TD4_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHK, DONE} state_t;
   localparam state_t AFTER_IMG = CHK;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam state_t AFTER_IMG = DONE;
`endif

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] rx_byte;
   logic              busy;
   logic              done;
   logic              cpu_rls;
   logic              shifting;
   logic              byte_end;
   logic              wr_en;
   logic              img_end;

   // start wins over a coincident bit, which is dropped
   assign rx_byte  = {shift[DATA_W-2:0], bus.sdi};
   assign shifting = busy && bus.ser_valid && !bus.start;
   assign byte_end = shifting && (bit_cnt == LAST_BIT);
   assign wr_en    = byte_end && (state == LOAD);
   assign img_end  = wr_en && (wr_addr == LAST_ADDR);

`ifdef TD4_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum;
   logic              err;
   logic              chk_ok;

   assign chk_ok = (rx_byte == sum);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.start) begin
         state_nxt = LOAD;
      end else begin
         unique case (state)
            LOAD: if (img_end) state_nxt = AFTER_IMG;
`ifdef TD4_LOADER_CHECKSUM_EN
            CHK:  if (byte_end) state_nxt = chk_ok ? DONE : IDLE;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      cpu_rls = 1'b0;
      unique case (state)
         LOAD: busy = 1'b1;
`ifdef TD4_LOADER_CHECKSUM_EN
         CHK:  busy = 1'b1;
`endif
         DONE: begin
            done    = 1'b1;
            cpu_rls = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift   <= '0;
         bit_cnt <= '0;
         wr_addr <= '0;
      end else if (bus.start) begin
         shift   <= '0;
         bit_cnt <= '0;
         wr_addr <= '0;
      end else if (shifting) begin
         shift   <= rx_byte;
         bit_cnt <= byte_end ? '0 : bit_cnt + 1'b1;
         if (wr_en) wr_addr <= wr_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= rx_byte;
      end
   end

`ifdef TD4_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum <= '0;
         err <= 1'b0;
      end else if (bus.start) begin
         sum <= '0;
         err <= 1'b0;
      end else begin
         if (wr_en) sum <= sum + rx_byte;
         if (byte_end && state == CHK && !chk_ok) err <= 1'b1;
      end
   end

   assign bus.err = err;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.cpu_data  = mem[bus.cpu_addr];
   assign bus.cpu_rst_n = cpu_rls;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.wr_addr   = wr_addr;
endmodule
